pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter CTRL_W, default 13, width of the control-field bundle (WB, MEM, EX controls) carried per entry.
REQ-002 Parameter DATA_W, default 84, width of the data-field bundle (two 32-bit operands plus four 5-bit fields) carried per entry.
REQ-003 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, released synchronously to clock.
REQ-006 flush  input  1  synchronous squash of all held entries (bubble insertion).
REQ-007 in_valid  input  1  upstream presents an entry.
REQ-008 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-009 in_data  input  DATA_W  upstream data bundle.
REQ-010 in_ready  output  1  stage can accept an entry this cycle; registered, no combinational path from out_ready.
REQ-011 out_valid  output  1  out_ctrl/out_data hold a live entry.
REQ-012 out_ctrl  output  CTRL_W  control bundle of head entry; all-zero when out_valid=0.
REQ-013 out_data  output  DATA_W  data bundle of head entry.
REQ-014 out_ready  input  1  downstream accepts head entry this cycle.
REQ-015 occupancy  output  2  number of held entries, 0..2.
REQ-016 stall_cnt  output  CNT_W  count of cycles with in_valid=1 and in_ready=0, saturating.

Function
REQ-017 Input transfer SHALL occur when in_valid=1 and in_ready=1; output transfer when out_valid=1 and out_ready=1.
REQ-018 Storage SHALL be two entries: main (drives outputs) and skid; states EMPTY (0), FULL (1), SKID (2).
REQ-019 EMPTY: input transfer -> main<=input, FULL; else hold EMPTY.
REQ-020 FULL: input and output transfer -> main<=input, stay FULL; input only -> skid<=input, SKID; output only -> EMPTY; neither -> hold.
REQ-021 SKID: in_ready=0; output transfer -> main<=skid, FULL; else hold all.
REQ-022 in_ready SHALL be 1 in EMPTY and FULL, 0 in SKID, updated only at clock edges.
REQ-023 Latency SHALL be one cycle from input transfer into EMPTY to out_valid=1 with that entry.
REQ-024 Entry order SHALL be preserved; no entry duplicated or dropped except by flush.
REQ-025 flush=1 SHALL take priority over every transfer: next state EMPTY, out_valid=0, out_ctrl=0, skid ctrl=0; any entry offered that cycle is discarded; data fields retain their old value.
REQ-026 out_ctrl SHALL be forced to zero whenever out_valid=0, so an empty stage is an architectural bubble.
REQ-027 occupancy SHALL equal the state encoding 0/1/2.
REQ-028 stall_cnt SHALL increment by 1 on each cycle with in_valid=1 and in_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.

Reset
REQ-029 While reset=0: state EMPTY, in_ready=1, out_valid=0, occupancy=0, stall_cnt=0, all ctrl and data registers 0.
REQ-030 Reset asserted mid-transfer SHALL discard all entries; first accept possible on first rising edge after release.

Structure
REQ-031 Package pipe_pkg SHALL hold the state enumeration (EMPTY, FULL, SKID) and default CTRL_W/DATA_W constants.
REQ-032 One sub-module pipe_entry_reg SHALL implement a single enable-loaded, clear-able ctrl+data entry; instantiated twice (main, skid).

Verification
REQ-033 Reset release, in_valid=1 with in_ctrl=0x1A5, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x1A5; occupancy=1.
REQ-034 Stream entries 1,2,3 with out_ready=0 -> after two accepts occupancy=2, in_ready=0; entry 3 held upstream; raise out_ready -> outputs 1,2,3 in order, no gaps.
REQ-035 occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1; offered entry never appears.
REQ-036 CNT_W=4, hold in_valid=1 in SKID with out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-037 Assert reset=0 mid-cycle in SKID -> outputs clear without a clock edge; after release stall_cnt=0, in_ready=1.
REQ-038 Random in_valid/out_ready/flush for 10k cycles vs reference queue model -> order matches, no loss except flushed entries.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
package pipe_pkg;

    localparam int CTRL_W_DEF = 13;
    localparam int DATA_W_DEF = 84;
    localparam int CNT_W_DEF  = 16;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry: the control half can be cleared on its own, so a
// flushed entry becomes a bubble while its data bits keep their old value.
module pipe_entry_reg #(
    parameter int CTRL_W = 13,
    parameter int DATA_W = 84
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_ctrl <= '0;
            q_data <= '0;
        end else begin
            if (clear) begin
                q_ctrl <= '0;
            end else if (load) begin
                q_ctrl <= d_ctrl;
                q_data <= d_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register. in_ready comes straight from a
// flop so the upstream handshake never depends combinationally on out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_t      state;
    stage_state_t      next_state;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;
    logic              clear_ctrl;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state != SKID);
            out_valid_q <= (next_state != EMPTY);
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_xfer) next_state = FULL;
                FULL: begin
                    if (in_xfer && !out_xfer)      next_state = SKID;
                    else if (!in_xfer && out_xfer) next_state = EMPTY;
                end
                SKID:    if (out_xfer) next_state = FULL;
                default: next_state = EMPTY;
            endcase
        end
    end

    // Flush wins over every load; only the control halves are wiped.
    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        clear_ctrl     = flush;
        if (!flush) begin
            case (state)
                EMPTY: main_load = in_xfer;
                FULL: begin
                    if (in_xfer && out_xfer) main_load = 1'b1;
                    else if (in_xfer)        skid_load = 1'b1;
                end
                SKID: begin
                    main_load      = out_xfer;
                    main_from_skid = out_xfer;
                end
                default: ;
            endcase
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clock  (clock),
        .reset  (reset),
        .load   (main_load),
        .clear  (clear_ctrl),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clock  (clock),
        .reset  (reset),
        .load   (skid_load),
        .clear  (clear_ctrl),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

    // Saturating count of cycles where upstream was held off; flush does not touch it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready_q && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = out_valid_q ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = 2'(state);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a long
// randomized run against a queue-based reference of the stage's contents.
module tb_pipe_stage_skid;

    localparam int CTRL_W = 13;
    localparam int DATA_W = 84;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clock;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    logic              s_in_ready;
    logic              s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_occupancy;
    logic [3:0]        s_stall_cnt;

    int   checks;
    int   errors;
    ent_t model_q[$];
    int   model_stall16;
    int   model_stall4;

    pipe_stage_skid dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(4)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_ctrl  (s_out_ctrl),
        .out_data  (s_out_data),
        .out_ready (out_ready),
        .occupancy (s_occupancy),
        .stall_cnt (s_stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance the reference by one edge using the inputs in force at that edge.
    task automatic tick();
        bit rdy;
        bit ix;
        bit ox;
        @(posedge clock);
        rdy = (model_q.size() < 2);
        ix  = in_valid && rdy;
        ox  = (model_q.size() > 0) && out_ready;
        if (in_valid && !rdy) begin
            if (model_stall16 < 65535) model_stall16++;
            if (model_stall4 < 15) model_stall4++;
        end
        if (flush) begin
            model_q.delete();
        end else begin
            if (ox) void'(model_q.pop_front());
            if (ix) model_q.push_back(ent_t'{c: in_ctrl, d: in_data});
        end
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_q.delete();
        model_stall16 = 0;
        model_stall4  = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("[TB] FAIL reset_out_ctrl got %h want 0", out_ctrl); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        in_valid  = 1'b1;
        in_ctrl   = 13'h1A5;
        in_data   = 84'h123;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_ctrl !== 13'h1A5) begin errors++; $display("[TB] FAIL single_ctrl got %h want 1a5", out_ctrl); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL single_occupancy got %0d want 1", occupancy); end
        checks++; if (out_data !== 84'h123) begin errors++; $display("[TB] FAIL single_data got %h want 123", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got %0b want 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("[TB] FAIL single_bubble_ctrl got %h want 0", out_ctrl); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 13'd1; in_data = 84'hA1;
        tick();
        checks++; if (occupancy !== 2'd1 || out_ctrl !== 13'd1) begin errors++; $display("[TB] FAIL b2b_first got occ=%0d ctrl=%h want occ=1 ctrl=1", occupancy, out_ctrl); end
        in_ctrl = 13'd2; in_data = 84'hA2;
        tick();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_skid got occ=%0d rdy=%0b want occ=2 rdy=0", occupancy, in_ready); end
        in_ctrl = 13'd3; in_data = 84'hA3;
        tick();
        checks++; if (occupancy !== 2'd2 || out_ctrl !== 13'd1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_hold got occ=%0d ctrl=%h rdy=%0b want occ=2 ctrl=1 rdy=0", occupancy, out_ctrl, in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 13'd2 || out_data !== 84'hA2) begin errors++; $display("[TB] FAIL b2b_out2 got v=%0b ctrl=%h data=%h want v=1 ctrl=2 data=a2", out_valid, out_ctrl, out_data); end
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_refill got occ=%0d rdy=%0b want occ=1 rdy=1", occupancy, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 13'd3 || out_data !== 84'hA3) begin errors++; $display("[TB] FAIL b2b_out3 got v=%0b ctrl=%h data=%h want v=1 ctrl=3 data=a3", out_valid, out_ctrl, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL b2b_empty got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("[TB] FAIL b2b_stall got %0d want 2", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 13'h11; in_data = 84'hB1;
        tick();
        in_ctrl = 13'h12; in_data = 84'hB2;
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("[TB] FAIL flush_fill got %0d want 2", occupancy); end
        flush   = 1'b1;
        in_ctrl = 13'h13; in_data = 84'hB3;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got occ=%0d v=%0b want occ=0 v=0", occupancy, out_valid); end
        checks++; if (out_ctrl !== '0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_bubble got ctrl=%h rdy=%0b want ctrl=0 rdy=1", out_ctrl, in_ready); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL flush_stall got %0d want 1", stall_cnt); end
        repeat (2) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_discard got v=%0b ctrl=%h want v=0", out_valid, out_ctrl); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 13'h21;
        tick();
        in_ctrl = 13'h22;
        tick();
        in_ctrl = 13'h23;
        repeat (20) tick();
        in_valid = 1'b0;
        checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_cnt4 got %0d want 15", s_stall_cnt); end
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("[TB] FAIL sat_cnt16 got %0d want 20", stall_cnt); end
        checks++; if (occupancy !== 2'd2 || out_ctrl !== 13'h21) begin errors++; $display("[TB] FAIL sat_hold got occ=%0d ctrl=%h want occ=2 ctrl=21", occupancy, out_ctrl); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 13'h31;
        tick();
        in_ctrl = 13'h32;
        tick();
        tick();
        checks++; if (stall_cnt !== 16'd1 || occupancy !== 2'd2) begin errors++; $display("[TB] FAIL areset_pre got cnt=%0d occ=%0d want cnt=1 occ=2", stall_cnt, occupancy); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin errors++; $display("[TB] FAIL areset_out got v=%0b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl); end
        checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_state got occ=%0d rdy=%0b want occ=0 rdy=1", occupancy, in_ready); end
        checks++; if (stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL areset_cnt got %0d/%0d want 0/0", stall_cnt, s_stall_cnt); end
        @(negedge clock);
        reset = 1'b1;
        model_q.delete();
        model_stall16 = 0;
        model_stall4  = 0;
        in_ctrl = 13'h0AB;
        in_data = 84'hC0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 13'h0AB || stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL areset_accept got v=%0b ctrl=%h cnt=%0d want v=1 ctrl=ab cnt=0", out_valid, out_ctrl, stall_cnt); end
    endtask

    task automatic test_random();
        bit              exp_valid;
        logic [CTRL_W-1:0] exp_ctrl;
        int              cycle_errors;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 3);
            in_ctrl   = CTRL_W'($urandom);
            in_data   = {$urandom, $urandom, 20'($urandom)};
            tick();
            exp_valid    = (model_q.size() > 0);
            exp_ctrl     = exp_valid ? model_q[0].c : '0;
            cycle_errors = 0;
            checks++; if (out_valid !== exp_valid) begin cycle_errors++; $display("[TB] FAIL rand_valid cyc=%0d got %0b want %0b", cyc, out_valid, exp_valid); end
            checks++; if (out_ctrl !== exp_ctrl) begin cycle_errors++; $display("[TB] FAIL rand_ctrl cyc=%0d got %h want %h", cyc, out_ctrl, exp_ctrl); end
            if (exp_valid) begin
                checks++; if (out_data !== model_q[0].d) begin cycle_errors++; $display("[TB] FAIL rand_data cyc=%0d got %h want %h", cyc, out_data, model_q[0].d); end
            end
            checks++; if (in_ready !== (model_q.size() < 2)) begin cycle_errors++; $display("[TB] FAIL rand_ready cyc=%0d got %0b want %0b", cyc, in_ready, model_q.size() < 2); end
            checks++; if (occupancy !== 2'(model_q.size())) begin cycle_errors++; $display("[TB] FAIL rand_occ cyc=%0d got %0d want %0d", cyc, occupancy, model_q.size()); end
            checks++; if (stall_cnt !== 16'(model_stall16)) begin cycle_errors++; $display("[TB] FAIL rand_stall cyc=%0d got %0d want %0d", cyc, stall_cnt, model_stall16); end
            checks++; if (s_stall_cnt !== 4'(model_stall4)) begin cycle_errors++; $display("[TB] FAIL rand_stall4 cyc=%0d got %0d want %0d", cyc, s_stall_cnt, model_stall4); end
            errors += cycle_errors;
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        model_stall16 = 0;
        model_stall4  = 0;
        reset         = 1'b1;
        flush         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        in_ctrl       = '0;
        in_data       = '0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_saturate();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
